// File: rtl/demux_alterno.sv
// Receive-side burst-alternating 1:2 demultiplexer: each valid burst goes to the
// opposite destination from the previous one, with registered outputs and per-output word counters.
`timescale 1ns/1ps
module demux_alterno #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic [DATA_W-1:0] data_in_c,
    input  logic              valid_in_c,
    output logic [DATA_W-1:0] data_out_0_c,
    output logic              valid_out_0_c,
    output logic [DATA_W-1:0] data_out_1_c,
    output logic              valid_out_1_c,
    output logic [CNT_W-1:0]  cnt_0_c,
    output logic [CNT_W-1:0]  cnt_1_c,
    output logic              dest_c
);

    localparam logic [4:0] INICIAL     = 5'd1;
    localparam logic [4:0] TRANS_0     = 5'd2;
    localparam logic [4:0] TRANS_1     = 5'd4;
    localparam logic [4:0] W_LST_DATA1 = 5'd8;
    localparam logic [4:0] W_LST_DATA0 = 5'd16;

    logic [4:0]        state_q, state_d;
    logic              route_0_s, route_1_s;
    logic [DATA_W-1:0] data_out_0_q, data_out_0_d;
    logic [DATA_W-1:0] data_out_1_q, data_out_1_d;
    logic              valid_out_0_q, valid_out_0_d;
    logic              valid_out_1_q, valid_out_1_d;
    logic [CNT_W-1:0]  cnt_0_q, cnt_0_d;
    logic [CNT_W-1:0]  cnt_1_q, cnt_1_d;
    logic              dest_q, dest_d;

    // State register; reset returns to INICIAL so the next burst always starts on destination 0.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state_q <= INICIAL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; any non-one-hot encoding falls back to INICIAL.
    always_comb begin
        state_d = state_q;
        case (state_q)
            INICIAL: begin
                if (valid_in_c) state_d = TRANS_0;
                else            state_d = INICIAL;
            end
            TRANS_0: begin
                if (valid_in_c) state_d = TRANS_0;
                else            state_d = W_LST_DATA0;
            end
            TRANS_1: begin
                if (valid_in_c) state_d = TRANS_1;
                else            state_d = W_LST_DATA1;
            end
            W_LST_DATA0: begin
                if (valid_in_c) state_d = TRANS_1;
                else            state_d = W_LST_DATA0;
            end
            W_LST_DATA1: begin
                if (valid_in_c) state_d = TRANS_0;
                else            state_d = W_LST_DATA1;
            end
            default: state_d = INICIAL;
        endcase
    end

    // Output decode: which destination (if any) takes the current word, and the next register values.
    always_comb begin
        route_0_s = 1'b0;
        route_1_s = 1'b0;
        case (state_q)
            INICIAL, TRANS_0, W_LST_DATA1: route_0_s = valid_in_c;
            TRANS_1, W_LST_DATA0:          route_1_s = valid_in_c;
            default: begin
                route_0_s = 1'b0;
                route_1_s = 1'b0;
            end
        endcase

        valid_out_0_d = route_0_s;
        valid_out_1_d = route_1_s;
        if (route_0_s) begin
            data_out_0_d = data_in_c;
            cnt_0_d      = cnt_0_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            data_out_0_d = {DATA_W{1'b0}};
            cnt_0_d      = cnt_0_q;
        end
        if (route_1_s) begin
            data_out_1_d = data_in_c;
            cnt_1_d      = cnt_1_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            data_out_1_d = {DATA_W{1'b0}};
            cnt_1_d      = cnt_1_q;
        end
        if (route_1_s) begin
            dest_d = 1'b1;
        end else if (route_0_s) begin
            dest_d = 1'b0;
        end else begin
            dest_d = dest_q;
        end
    end

    // Output registers; reset dominates any word presented on the same edge.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            data_out_0_q  <= {DATA_W{1'b0}};
            data_out_1_q  <= {DATA_W{1'b0}};
            valid_out_0_q <= 1'b0;
            valid_out_1_q <= 1'b0;
            cnt_0_q       <= {CNT_W{1'b0}};
            cnt_1_q       <= {CNT_W{1'b0}};
            dest_q        <= 1'b0;
        end else begin
            data_out_0_q  <= data_out_0_d;
            data_out_1_q  <= data_out_1_d;
            valid_out_0_q <= valid_out_0_d;
            valid_out_1_q <= valid_out_1_d;
            cnt_0_q       <= cnt_0_d;
            cnt_1_q       <= cnt_1_d;
            dest_q        <= dest_d;
        end
    end

    assign data_out_0_c  = data_out_0_q;
    assign data_out_1_c  = data_out_1_q;
    assign valid_out_0_c = valid_out_0_q;
    assign valid_out_1_c = valid_out_1_q;
    assign cnt_0_c       = cnt_0_q;
    assign cnt_1_c       = cnt_1_q;
    assign dest_c        = dest_q;

endmodule

// File: tb/tb_demux_alterno.sv
// Bench for demux_alterno: directed bursts push expected words per destination into queues;
// a negedge monitor pops and compares whenever an output is valid.
`timescale 1ns/1ps
module tb_demux_alterno;

    typedef struct {
        logic [7:0] d;
        int         c;
    } exp_t;

    logic       clk;
    logic       reset_L;
    logic [7:0] data_in_c;
    logic       valid_in_c;
    logic [7:0] data_out_0_c, data_out_1_c;
    logic       valid_out_0_c, valid_out_1_c;
    logic [7:0] cnt_0_c, cnt_1_c;
    logic       dest_c;

    exp_t q0[$];
    exp_t q1[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    logic mon_en   = 1'b0;

    demux_alterno #(.DATA_W(8), .CNT_W(8)) dut (
        .clk           (clk),
        .reset_L       (reset_L),
        .data_in_c     (data_in_c),
        .valid_in_c    (valid_in_c),
        .data_out_0_c  (data_out_0_c),
        .valid_out_0_c (valid_out_0_c),
        .data_out_1_c  (data_out_1_c),
        .valid_out_1_c (valid_out_1_c),
        .cnt_0_c       (cnt_0_c),
        .cnt_1_c       (cnt_1_c),
        .dest_c        (dest_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
        end
    endtask

    // Drive one cycle of input; dst = 0/1 pushes an expected word, -1 means nothing should come out.
    task automatic drive(input logic v, input logic [7:0] d, input int dst);
        exp_t e;
        e.d = d;
        e.c = cyc + 1;
        if (v && reset_L && dst == 0) q0.push_back(e);
        if (v && reset_L && dst == 1) q1.push_back(e);
        valid_in_c = v;
        data_in_c  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        drive(1'b0, 8'h00, -1);
        reset_L = 1'b1;
    endtask

    // Monitor: pop and compare on every valid output, otherwise require zeroed data.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (valid_out_0_c && valid_out_1_c) chk("both_valid", 1, 0);
            if (valid_out_0_c) begin
                if (q0.size() == 0) begin
                    chk("out0_unexpected", int'(data_out_0_c), -1);
                end else begin
                    e = q0.pop_front();
                    chk("out0_data", int'(data_out_0_c), int'(e.d));
                    chk("out0_latency", cyc, e.c);
                end
            end else begin
                chk("out0_idle_zero", int'(data_out_0_c), 0);
            end
            if (valid_out_1_c) begin
                if (q1.size() == 0) begin
                    chk("out1_unexpected", int'(data_out_1_c), -1);
                end else begin
                    e = q1.pop_front();
                    chk("out1_data", int'(data_out_1_c), int'(e.d));
                    chk("out1_latency", cyc, e.c);
                end
            end else begin
                chk("out1_idle_zero", int'(data_out_1_c), 0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_L    = 1'b0;
        valid_in_c = 1'b0;
        data_in_c  = 8'h00;
        drive(1'b1, 8'hEE, -1);
        drive(1'b1, 8'hEF, -1);
        mon_en = 1'b1;
        chk("rst_valid0", int'(valid_out_0_c), 0);
        chk("rst_valid1", int'(valid_out_1_c), 0);
        chk("rst_cnt0", int'(cnt_0_c), 0);
        chk("rst_cnt1", int'(cnt_1_c), 0);
        chk("rst_dest", int'(dest_c), 0);
        chk("rst_state", int'(dut.state_q), 1);
        reset_L = 1'b1;

        // Single burst to destination 0
        drive(1'b1, 8'hA1, 0);
        drive(1'b1, 8'hA2, 0);
        drive(1'b1, 8'hA3, 0);
        drive(1'b0, 8'h00, -1);
        chk("b1_cnt0", int'(cnt_0_c), 3);
        chk("b1_cnt1", int'(cnt_1_c), 0);
        chk("b1_dest", int'(dest_c), 0);

        // Alternating bursts with gaps of 3 and 1 cycles
        do_reset();
        drive(1'b1, 8'h10, 0);
        drive(1'b1, 8'h11, 0);
        repeat (3) drive(1'b0, 8'h5A, -1);
        drive(1'b1, 8'h20, 1);
        drive(1'b0, 8'hA5, -1);
        chk("alt_dest_mid", int'(dest_c), 1);
        drive(1'b1, 8'h30, 0);
        drive(1'b1, 8'h31, 0);
        drive(1'b0, 8'h00, -1);
        drive(1'b0, 8'h00, -1);
        chk("alt_cnt0", int'(cnt_0_c), 4);
        chk("alt_cnt1", int'(cnt_1_c), 1);
        chk("alt_dest", int'(dest_c), 0);

        // Long burst: counter wraps, state stays in TRANS_0
        do_reset();
        for (int i = 0; i < 300; i++) drive(1'b1, i[7:0], 0);
        chk("long_cnt0", int'(cnt_0_c), 44);
        chk("long_cnt1", int'(cnt_1_c), 0);
        chk("long_state", int'(dut.state_q), 2);
        drive(1'b0, 8'h00, -1);

        // Reset during the second word of a destination-1 burst
        do_reset();
        drive(1'b1, 8'h01, 0);
        drive(1'b0, 8'h00, -1);
        drive(1'b1, 8'h02, 1);
        reset_L = 1'b0;
        drive(1'b1, 8'h03, -1);
        reset_L = 1'b1;
        chk("mid_rst_valid0", int'(valid_out_0_c), 0);
        chk("mid_rst_valid1", int'(valid_out_1_c), 0);
        chk("mid_rst_cnt0", int'(cnt_0_c), 0);
        chk("mid_rst_cnt1", int'(cnt_1_c), 0);
        drive(1'b1, 8'h55, 0);
        drive(1'b0, 8'h00, -1);
        chk("post_rst_cnt0", int'(cnt_0_c), 1);
        chk("post_rst_cnt1", int'(cnt_1_c), 0);
        chk("post_rst_dest", int'(dest_c), 0);

        // Idle input with toggling data must be ignored
        for (int i = 0; i < 20; i++) drive(1'b0, (i % 2 == 0) ? 8'hFF : 8'h00, -1);
        chk("idle_cnt0", int'(cnt_0_c), 1);
        chk("idle_cnt1", int'(cnt_1_c), 0);
        chk("idle_dest", int'(dest_c), 0);
        chk("idle_valid0", int'(valid_out_0_c), 0);
        chk("idle_valid1", int'(valid_out_1_c), 0);

        @(negedge clk);
        mon_en = 1'b0;
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/demux_alterno.md
DEMUX_ALTERNO -- requirements
Module: demux_alterno

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, width of the data path.
REQ-002 The block SHALL have parameter CNT_W, default 8, width of each per-output word counter.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_L  input  1  reset, synchronous and active-low.
REQ-005 The block SHALL have port data_in_c  input  DATA_W  input stream word.
REQ-006 The block SHALL have port valid_in_c  input  1  data_in_c qualifier; a contiguous run of 1s is one burst.
REQ-007 The block SHALL have port data_out_0_c  output  DATA_W  destination-0 word.
REQ-008 The block SHALL have port valid_out_0_c  output  1  destination-0 qualifier.
REQ-009 The block SHALL have port data_out_1_c  output  DATA_W  destination-1 word.
REQ-010 The block SHALL have port valid_out_1_c  output  1  destination-1 qualifier.
REQ-011 The block SHALL have port cnt_0_c  output  CNT_W  words delivered to destination 0.
REQ-012 The block SHALL have port cnt_1_c  output  CNT_W  words delivered to destination 1.
REQ-013 The block SHALL have port dest_c  output  1  destination of the most recent word (0 or 1).

Function
REQ-014 The block SHALL be the receive-side counterpart of the 2:1 burst-alternating mux: it SHALL split one valid-qualified stream into two, alternating destination per burst.
REQ-015 The FSM SHALL be one-hot, 5 bits: INICIAL=1, TRANS_0=2, TRANS_1=4, W_LST_DATA1=8, W_LST_DATA0=16.
REQ-016 INICIAL: valid_in_c=1 -> route to 0, go TRANS_0; valid_in_c=0 -> stay.
REQ-017 TRANS_0: valid_in_c=1 -> route to 0, stay; valid_in_c=0 -> W_LST_DATA0, nothing routed.
REQ-018 TRANS_1: valid_in_c=1 -> route to 1, stay; valid_in_c=0 -> W_LST_DATA1, nothing routed.
REQ-019 W_LST_DATA0: valid_in_c=1 -> route to 1, go TRANS_1; else stay.
REQ-020 W_LST_DATA1: valid_in_c=1 -> route to 0, go TRANS_0; else stay.
REQ-021 Any non-one-hot state value SHALL go to INICIAL on the next edge with no word routed.
REQ-022 Outputs SHALL be registered: a word accepted at edge N SHALL appear on the selected data_out_x_c with valid_out_x_c=1 during cycle N to N+1 (latency 1 cycle).
REQ-023 At most one of valid_out_0_c/valid_out_1_c SHALL be 1 in any cycle.
REQ-024 A data_out_x_c whose valid_out_x_c is 0 SHALL read all-zero.
REQ-025 A one-cycle gap (valid_in_c low for one edge) SHALL end the burst; the next word SHALL go to the other destination.
REQ-026 cnt_x_c SHALL increment by 1 in the same edge that asserts valid_out_x_c, wrapping from 2^CNT_W-1 to 0 without flag.
REQ-027 dest_c SHALL update with each routed word and hold otherwise.
REQ-028 data_in_c SHALL be ignored whenever valid_in_c=0.

Reset
REQ-029 At any rising clk edge with reset_L=0: state=INICIAL, all data/valid outputs 0, cnt_0_c=cnt_1_c=0, dest_c=0.
REQ-030 reset_L=0 SHALL dominate valid_in_c; a word presented on a reset edge SHALL be dropped and not counted.
REQ-031 Reset asserted mid-burst SHALL abort it; the first burst after release SHALL go to destination 0.
REQ-032 No output SHALL change asynchronously on reset_L.

Verification
REQ-033 Reset, then burst 0xA1,0xA2,0xA3 -> out0 shows A1,A2,A3 on three consecutive cycles, each 1 cycle after input; cnt_0_c=3, valid_out_1_c never 1.
REQ-034 Bursts 0x10,0x11 | gap 3 cycles | 0x20 | gap 1 | 0x30,0x31 -> out0: 10,11,30,31; out1: 20; cnt_0_c=4, cnt_1_c=1, dest_c=0 at end.
REQ-035 Continuous valid_in_c for 300 cycles with data=cycle index -> all on out0, cnt_0_c=300 mod 256=44, state stays TRANS_0.
REQ-036 reset_L low for one edge during 2nd word of a burst on out1 -> both valids 0 next cycle, counters 0; next burst 0x55 -> out0, cnt_0_c=1.
REQ-037 valid_in_c=0 with data_in_c toggling 0xFF/0x00 for 20 cycles -> both valids 0, both data outputs 0x00, counters unchanged.
